interrupt_arbiter: RTL and testbench

INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

---
 rtl/interrupt_arbiter.sv | 170 +++++++++++++++++
 tb/tb_interrupt_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : interrupt_arbiter
//  Purpose  : Machine-interrupt arbiter. Keeps a pending vector fed by level-
//             and edge-triggered sources, selects the highest-index enabled
//             pending source, and presents it to the commit unit. The request
//             is held until it is acknowledged or withdrawn.
//  Ports    : cpu_clock_i              - clock, rising edge
//             cpu_reset_i              - synchronous active-high reset
//             current_privilege_mode_i - 1 = M-mode, 0 = lower privilege
//             mie_i                    - mstatus.MIE global enable
//             int_en_i  [NUM_SRC]      - per-source enable (mie CSR)
//             irq_i     [NUM_SRC]      - raw interrupt lines
//             int_ack_i                - commit unit took the interrupt
//             int_o                    - registered interrupt request
//             int_type_o[CAUSE_W]      - registered cause of the request
//             mip_o     [NUM_SRC]      - registered pending vector
//  Revision : 1.0 - initial release
// ============================================================================
module interrupt_arbiter #(
    parameter int                           NUM_SRC   = 3,
    parameter int                           CAUSE_W   = 4,
    parameter logic [NUM_SRC*CAUSE_W-1:0]   CAUSE_MAP = {4'd11, 4'd3, 4'd7},
    parameter logic [NUM_SRC-1:0]           EDGE_MASK = '0
) (
    input  logic                cpu_clock_i,
    input  logic                cpu_reset_i,
    input  logic                current_privilege_mode_i,
    input  logic                mie_i,
    input  logic [NUM_SRC-1:0]  int_en_i,
    input  logic [NUM_SRC-1:0]  irq_i,
    input  logic                int_ack_i,
    output logic                int_o,
    output logic [CAUSE_W-1:0]  int_type_o,
    output logic [NUM_SRC-1:0]  mip_o
);

    localparam int c_IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [NUM_SRC-1:0]   r_pend;
    logic [NUM_SRC-1:0]   w_pend_nxt;
    logic [NUM_SRC-1:0]   w_cand;
    logic [c_IDX_W-1:0]   r_sel;
    logic [c_IDX_W-1:0]   w_sel_nxt;
    logic [c_IDX_W-1:0]   w_top_idx;
    logic [CAUSE_W-1:0]   r_cause;
    logic [CAUSE_W-1:0]   w_cause_nxt;
    logic [CAUSE_W-1:0]   w_top_cause;
    logic                 w_gate;
    logic                 w_any;
    logic                 w_sel_live;
    logic                 w_accept;

    // Interrupts are always taken below M-mode; in M-mode only with MIE set.
    assign w_gate = (~current_privilege_mode_i) | mie_i;
    assign w_cand = r_pend & int_en_i;
    assign w_any  = |w_cand;

    // Highest set index wins: later iterations overwrite earlier ones.
    always_comb begin
        w_top_idx   = '0;
        w_top_cause = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_cand[i]) begin
                w_top_idx   = c_IDX_W'(i);
                w_top_cause = CAUSE_MAP[i*CAUSE_W +: CAUSE_W];
            end
        end
    end

    // Is the source currently being presented still an enabled candidate?
    always_comb begin
        w_sel_live = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_sel == c_IDX_W'(i)) begin
                w_sel_live = w_cand[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending vector. Level sources simply follow the line; edge sources
    // keep a previous-value flop and stay pending until their own ack.
    // A fresh edge coinciding with the ack keeps the bit set.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        if (EDGE_MASK[i]) begin : g_edge
            logic r_prev;
            logic w_clr;

            always_ff @(posedge cpu_clock_i) begin
                if (cpu_reset_i) begin
                    r_prev <= 1'b0;
                end else begin
                    r_prev <= irq_i[i];
                end
            end

            assign w_clr         = w_accept && (r_sel == c_IDX_W'(i));
            assign w_pend_nxt[i] = (irq_i[i] & ~r_prev) | (r_pend[i] & ~w_clr);
        end else begin : g_level
            assign w_pend_nxt[i] = irq_i[i];
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clock_i) begin
        if (cpu_reset_i) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_cause <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cause_nxt = r_cause;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An ack seen here is stale and deliberately ignored.
                if (w_gate && w_any) begin
                    w_state_nxt = ST_REQ;
                    w_sel_nxt   = w_top_idx;
                    w_cause_nxt = w_top_cause;
                end
            end
            ST_REQ: begin
                // Selection is frozen while requesting; ack beats withdraw.
                if (int_ack_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!w_gate || !w_sel_live) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign int_o      = (r_state == ST_REQ);
    assign int_type_o = r_cause;
    assign mip_o      = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_interrupt_arbiter
//  Purpose  : Self-checking bench for interrupt_arbiter (source 1 edge-
//             triggered, sources 0 and 2 level-triggered). Directed scenarios
//             followed by randomized traffic, all compared every cycle with a
//             behavioural model of the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_interrupt_arbiter;

    localparam int         c_N    = 3;
    localparam logic [2:0] c_EDGE = 3'b010;

    logic       clk = 1'b0;
    logic       rst;
    logic       priv;
    logic       mie;
    logic [2:0] en;
    logic [2:0] irq;
    logic       ack;
    logic       int_o;
    logic [3:0] int_type;
    logic [2:0] mip;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    bit m_pend [c_N];
    bit m_prev [c_N];
    bit m_busy;
    int m_sel;
    int m_cause;
    int cause_of [c_N] = '{7, 3, 11};

    interrupt_arbiter #(
        .NUM_SRC   (3),
        .CAUSE_W   (4),
        .CAUSE_MAP ({4'd11, 4'd3, 4'd7}),
        .EDGE_MASK (c_EDGE)
    ) u_dut (
        .cpu_clock_i              (clk),
        .cpu_reset_i              (rst),
        .current_privilege_mode_i (priv),
        .mie_i                    (mie),
        .int_en_i                 (en),
        .irq_i                    (irq),
        .int_ack_i                (ack),
        .int_o                    (int_o),
        .int_type_o               (int_type),
        .mip_o                    (mip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge applied to the rule set, using the inputs the DUT sees.
    task automatic model_edge();
        bit gate;
        bit cand [c_N];
        bit any;
        int top;
        bit new_pend [c_N];
        if (rst) begin
            for (int i = 0; i < c_N; i++) begin
                m_pend[i] = 0;
                m_prev[i] = 0;
            end
            m_busy  = 0;
            m_sel   = 0;
            m_cause = 0;
            return;
        end
        gate = !priv || mie;
        any  = 0;
        top  = 0;
        for (int i = 0; i < c_N; i++) begin
            cand[i] = m_pend[i] && en[i];
            if (cand[i]) begin
                any = 1;
                top = i;
            end
        end
        for (int i = 0; i < c_N; i++) begin
            if (!c_EDGE[i]) begin
                new_pend[i] = irq[i];
            end else if (irq[i] && !m_prev[i]) begin
                new_pend[i] = 1;
            end else if (m_busy && ack && m_sel == i) begin
                new_pend[i] = 0;
            end else begin
                new_pend[i] = m_pend[i];
            end
        end
        if (!m_busy) begin
            if (gate && any) begin
                m_busy  = 1;
                m_sel   = top;
                m_cause = cause_of[top];
            end
        end else if (ack) begin
            m_busy = 0;
        end else if (!gate || !cand[m_sel]) begin
            m_busy = 0;
        end
        for (int i = 0; i < c_N; i++) begin
            m_pend[i] = new_pend[i];
            m_prev[i] = irq[i];
        end
    endtask

    task automatic step();
        logic [2:0] exp_mip;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < c_N; i++) exp_mip[i] = m_pend[i];
        check("int_o",    32'(int_o),    32'(m_busy));
        check("int_type", 32'(int_type), 32'(m_cause));
        check("mip",      32'(mip),      32'(exp_mip));
    endtask

    task automatic drive(input logic r, input logic p, input logic m,
                         input logic [2:0] e, input logic [2:0] q, input logic a);
        rst = r; priv = p; mie = m; en = e; irq = q; ack = a;
    endtask

    task automatic do_reset();
        drive(1, 1, 1, 3'b111, 3'b000, 0);
        step();
        drive(0, 1, 1, 3'b111, 3'b000, 0);
    endtask

    initial begin
        drive(1, 1, 1, 3'b111, 3'b000, 0);
        step();
        check("reset_int_o", 32'(int_o), 0);
        check("reset_type",  32'(int_type), 0);
        check("reset_mip",   32'(mip), 0);

        // Level source 0: request, ack, re-request.
        drive(0, 1, 1, 3'b111, 3'b001, 0);
        step();
        check("lvl_latency_lo", 32'(int_o), 0);
        step();
        check("lvl_req", 32'(int_o), 1);
        check("lvl_cause", 32'(int_type), 7);
        ack = 1; step();
        check("lvl_ack_drop", 32'(int_o), 0);
        ack = 0; step();
        check("lvl_rereq", 32'(int_o), 1);

        // Priority: index 2 beats index 0.
        do_reset();
        irq = 3'b101; step(); step();
        check("prio_cause", 32'(int_type), 11);
        ack = 1; irq = 3'b001; step();
        check("prio_hold_type", 32'(int_type), 11);
        ack = 0; step();
        check("prio_next_cause", 32'(int_type), 7);

        // Edge source 1: single pulse stays pending until ack.
        do_reset();
        irq = 3'b010; step();
        irq = 3'b000; step();
        check("edge_req", 32'(int_o), 1);
        check("edge_cause", 32'(int_type), 3);
        step(); step();
        check("edge_mip_held", 32'(mip), 3'b010);
        ack = 1; step();
        check("edge_mip_clr", 32'(mip), 0);
        check("edge_ack_drop", 32'(int_o), 0);
        ack = 0; step();

        // Withdraw on mie drop in M-mode, re-assert in lower privilege.
        do_reset();
        irq = 3'b001; step(); step();
        check("wd_req", 32'(int_o), 1);
        mie = 0; step();
        check("wd_drop", 32'(int_o), 0);
        check("wd_mip", 32'(mip), 3'b001);
        step();
        check("wd_stay", 32'(int_o), 0);
        priv = 0; step();
        check("wd_lowpriv", 32'(int_o), 1);

        // New edge coincident with ack, then reset during REQ.
        do_reset();
        irq = 3'b010; step();
        irq = 3'b000; step();
        ack = 1; irq = 3'b010; step();
        check("ae_idle", 32'(int_o), 0);
        check("ae_mip", 32'(mip), 3'b010);
        ack = 0; irq = 3'b000; step();
        check("ae_second", 32'(int_o), 1);
        rst = 1; ack = 1; irq = 3'b010; step();
        check("rst_int_o", 32'(int_o), 0);
        check("rst_type", 32'(int_type), 0);
        check("rst_mip", 32'(mip), 0);
        // Edge line held high across reset release registers one edge.
        rst = 0; ack = 0; step();
        check("rst_rel_edge", 32'(mip), 3'b010);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            rst  = ($urandom_range(0, 99) == 0);
            priv = ($urandom_range(0, 3) != 0);
            mie  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) en = 3'($urandom);
            irq  = irq ^ 3'($urandom & $urandom);
            ack  = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
